// File: rtl/afe_ldst_align_pipe_pkg.sv
// ----------------------------------------------------------------------------
// afe_ldst_align_pipe_pkg : load-op codes, access-size decode shared by the aligner
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

// Operation codes normally come from the core-wide header; supply them if absent.
`ifndef AFE_LDST_NONE
`define AFE_LDST_NONE      4'd0
`define AFE_LDST_SEXT8_32  4'd1
`define AFE_LDST_SEXT16_32 4'd2
`define AFE_LDST_ZEXT8_32  4'd3
`define AFE_LDST_ZEXT16_32 4'd4
`define AFE_LDST_SEXT32_64 4'd5
`define AFE_LDST_ZEXT32_64 4'd6
`endif

package afe_ldst_align_pipe_pkg;

  localparam int C_CODE_W = 4;

  typedef enum logic [1:0] {
    ACC_FULL = 2'd0,
    ACC_BYTE = 2'd1,
    ACC_HALF = 2'd2,
    ACC_WORD = 2'd3
  } acc_size_e;

  typedef struct packed {
    acc_size_e size;
    logic      sext;
  } acc_dec_t;

  // 32-bit lane ops exist only on a 64-bit datapath; elsewhere they pass the word.
  function automatic acc_dec_t decode_code(input logic [C_CODE_W-1:0] code, input int data_w);
    acc_dec_t dec;
    dec.size = ACC_FULL;
    dec.sext = 1'b0;
    case (code)
      `AFE_LDST_SEXT8_32:  begin dec.size = ACC_BYTE; dec.sext = 1'b1; end
      `AFE_LDST_ZEXT8_32:  begin dec.size = ACC_BYTE; dec.sext = 1'b0; end
      `AFE_LDST_SEXT16_32: begin dec.size = ACC_HALF; dec.sext = 1'b1; end
      `AFE_LDST_ZEXT16_32: begin dec.size = ACC_HALF; dec.sext = 1'b0; end
      `AFE_LDST_SEXT32_64: if (data_w == 64) begin dec.size = ACC_WORD; dec.sext = 1'b1; end
      `AFE_LDST_ZEXT32_64: if (data_w == 64) begin dec.size = ACC_WORD; dec.sext = 1'b0; end
      default: ;
    endcase
    return dec;
  endfunction

endpackage

`default_nettype wire

// File: rtl/afe_ldst_extract.sv
// ----------------------------------------------------------------------------
// afe_ldst_extract : combinational lane select + sign/zero extend of load data
// Optional: AFE_LDST_MISALIGN_TRAP_EN flags misaligned half/word accesses
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module afe_ldst_extract
  import afe_ldst_align_pipe_pkg::*;
#(
  parameter int P_DATA_W = 32,
  parameter int P_OFS_W  = 2
) (
  input  logic [C_CODE_W-1:0] i_code,
  input  logic [P_OFS_W-1:0]  i_offset,
  input  logic [P_DATA_W-1:0] i_data,
  output logic [P_DATA_W-1:0] o_data,
  output logic                o_fault
);

  localparam int C_NBYTES = P_DATA_W / 8;

  acc_dec_t              w_dec;
  logic [P_OFS_W-1:0]    w_idx;
  logic [P_DATA_W-1:0]   w_rot;
  logic [P_DATA_W-1:0]   w_ext;

  assign w_dec = decode_code(i_code, P_DATA_W);

  // Byte-granular rotate right; the modulo-N index makes over-the-top fields wrap to byte 0.
  always_comb begin
    w_rot = '0;
    w_idx = '0;
    for (int i = 0; i < C_NBYTES; i++) begin
      w_idx           = P_OFS_W'(i) + i_offset;
      w_rot[i*8 +: 8] = i_data[{w_idx, 3'b000} +: 8];
    end
  end

  always_comb begin
    w_ext = i_data;
    case (w_dec.size)
      ACC_BYTE: w_ext = w_dec.sext ? P_DATA_W'($signed(w_rot[7:0]))  : P_DATA_W'(w_rot[7:0]);
      ACC_HALF: w_ext = w_dec.sext ? P_DATA_W'($signed(w_rot[15:0])) : P_DATA_W'(w_rot[15:0]);
      ACC_WORD: w_ext = w_dec.sext ? P_DATA_W'($signed(w_rot[31:0])) : P_DATA_W'(w_rot[31:0]);
      default:  w_ext = i_data;
    endcase
  end

`ifdef AFE_LDST_MISALIGN_TRAP_EN
  logic w_misalign;

  always_comb begin
    w_misalign = 1'b0;
    if (w_dec.size == ACC_HALF) w_misalign = i_offset[0];
    if (w_dec.size == ACC_WORD) w_misalign = |i_offset[1:0];
  end

  assign o_fault = w_misalign;
  assign o_data  = w_misalign ? '0 : w_ext;
`else
  assign o_fault = 1'b0;
  assign o_data  = w_ext;
`endif

endmodule

`default_nettype wire

// File: rtl/afe_ldst_align_pipe.sv
// ----------------------------------------------------------------------------
// afe_ldst_align_pipe : 2-stage load aligner with occupancy-limited output FIFO
// Optional: AFE_LDST_MISALIGN_TRAP_EN (handled in afe_ldst_extract)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module afe_ldst_align_pipe
  import afe_ldst_align_pipe_pkg::*;
#(
  parameter int P_DATA_W     = 32,
  parameter int P_OFS_W      = 2,
  parameter int P_TAG_W      = 5,
  parameter int P_FIFO_DEPTH = 2
) (
  input  logic                iCLOCK,
  input  logic                iRESET_SYNC,
  input  logic                iFLUSH,
  input  logic                iREQ_VALID,
  output logic                oREQ_BUSY,
  input  logic [3:0]          iREQ_CODE,
  input  logic [P_OFS_W-1:0]  iREQ_OFFSET,
  input  logic [P_DATA_W-1:0] iREQ_DATA,
  input  logic [P_TAG_W-1:0]  iREQ_TAG,
  output logic                oOUT_VALID,
  input  logic                iOUT_BUSY,
  output logic [P_DATA_W-1:0] oOUT_DATA,
  output logic [P_TAG_W-1:0]  oOUT_TAG,
  output logic                oOUT_FAULT
);

  localparam int C_PTR_W = (P_FIFO_DEPTH > 1) ? $clog2(P_FIFO_DEPTH) : 1;
  localparam int C_CNT_W = $clog2(P_FIFO_DEPTH + 1);

  typedef struct packed {
    logic [P_DATA_W-1:0] data;
    logic [P_TAG_W-1:0]  tag;
    logic                fault;
  } fifo_ent_t;

  logic                s1_valid_q, s1_valid_d;
  logic [3:0]          s1_code_q,  s1_code_d;
  logic [P_OFS_W-1:0]  s1_ofs_q,   s1_ofs_d;
  logic [P_DATA_W-1:0] s1_data_q,  s1_data_d;
  logic [P_TAG_W-1:0]  s1_tag_q,   s1_tag_d;

  fifo_ent_t           mem_q [P_FIFO_DEPTH];
  fifo_ent_t           mem_d [P_FIFO_DEPTH];
  logic [C_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [C_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [C_CNT_W-1:0]  fcnt_q,   fcnt_d;
  logic [C_CNT_W-1:0]  occ_q,    occ_d;

  logic                w_busy;
  logic                w_accept;
  logic                w_pop;
  logic [P_DATA_W-1:0] w_ext_data;
  logic                w_ext_fault;

  afe_ldst_extract #(
    .P_DATA_W (P_DATA_W),
    .P_OFS_W  (P_OFS_W)
  ) u_extract (
    .i_code   (s1_code_q),
    .i_offset (s1_ofs_q),
    .i_data   (s1_data_q),
    .o_data   (w_ext_data),
    .o_fault  (w_ext_fault)
  );

  // Busy depends only on registered occupancy and flush, never on iOUT_BUSY.
  assign w_busy     = (occ_q == C_CNT_W'(P_FIFO_DEPTH)) | iFLUSH;
  assign w_accept   = iREQ_VALID & ~w_busy;
  assign oOUT_VALID = (fcnt_q != '0);
  assign w_pop      = oOUT_VALID & ~iOUT_BUSY;

  assign oREQ_BUSY  = w_busy;
  assign oOUT_DATA  = mem_q[rd_ptr_q].data;
  assign oOUT_TAG   = mem_q[rd_ptr_q].tag;
  assign oOUT_FAULT = mem_q[rd_ptr_q].fault;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_ofs_d   = s1_ofs_q;
    s1_data_d  = s1_data_q;
    s1_tag_d   = s1_tag_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fcnt_d     = fcnt_q;
    occ_d      = occ_q;

    if (iFLUSH) begin
      // Empty by pulling the write pointer back; the head entry stays put so outputs hold.
      s1_valid_d = 1'b0;
      wr_ptr_d   = rd_ptr_q;
      fcnt_d     = '0;
      occ_d      = '0;
    end else begin
      s1_valid_d = w_accept;
      if (w_accept) begin
        s1_code_d = iREQ_CODE;
        s1_ofs_d  = iREQ_OFFSET;
        s1_data_d = iREQ_DATA;
        s1_tag_d  = iREQ_TAG;
      end

      if (s1_valid_q) begin
        mem_d[wr_ptr_q] = '{data: w_ext_data, tag: s1_tag_q, fault: w_ext_fault};
        wr_ptr_d        = wr_ptr_q + C_PTR_W'(1);
      end
      if (w_pop) rd_ptr_d = rd_ptr_q + C_PTR_W'(1);

      case ({s1_valid_q, w_pop})
        2'b10:   fcnt_d = fcnt_q + C_CNT_W'(1);
        2'b01:   fcnt_d = fcnt_q - C_CNT_W'(1);
        default: fcnt_d = fcnt_q;
      endcase

      case ({w_accept, w_pop})
        2'b10:   occ_d = occ_q + C_CNT_W'(1);
        2'b01:   occ_d = occ_q - C_CNT_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_ofs_q   <= '0;
      s1_data_q  <= '0;
      s1_tag_q   <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
      occ_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_code_q  <= s1_code_d;
      s1_ofs_q   <= s1_ofs_d;
      s1_data_q  <= s1_data_d;
      s1_tag_q   <= s1_tag_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
      occ_q      <= occ_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_afe_ldst_align_pipe.sv
// ----------------------------------------------------------------------------
// tb_afe_ldst_align_pipe : scoreboard bench, 32-bit/depth-2 and 64-bit/depth-4 instances
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

`ifndef AFE_LDST_NONE
`define AFE_LDST_NONE      4'd0
`define AFE_LDST_SEXT8_32  4'd1
`define AFE_LDST_SEXT16_32 4'd2
`define AFE_LDST_ZEXT8_32  4'd3
`define AFE_LDST_ZEXT16_32 4'd4
`define AFE_LDST_SEXT32_64 4'd5
`define AFE_LDST_ZEXT32_64 4'd6
`endif

module tb_afe_ldst_align_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_flush, a_req_valid, a_req_busy, a_out_valid, a_out_busy, a_out_fault;
  logic [3:0]  a_req_code;
  logic [1:0]  a_req_ofs;
  logic [31:0] a_req_data, a_out_data;
  logic [4:0]  a_req_tag, a_out_tag;

  logic        b_flush, b_req_valid, b_req_busy, b_out_valid, b_out_busy, b_out_fault;
  logic [3:0]  b_req_code;
  logic [2:0]  b_req_ofs;
  logic [63:0] b_req_data, b_out_data;
  logic [4:0]  b_req_tag, b_out_tag;

  afe_ldst_align_pipe #(.P_DATA_W(32), .P_OFS_W(2), .P_TAG_W(5), .P_FIFO_DEPTH(2)) dut_a (
    .iCLOCK(clk), .iRESET_SYNC(rst), .iFLUSH(a_flush),
    .iREQ_VALID(a_req_valid), .oREQ_BUSY(a_req_busy), .iREQ_CODE(a_req_code),
    .iREQ_OFFSET(a_req_ofs), .iREQ_DATA(a_req_data), .iREQ_TAG(a_req_tag),
    .oOUT_VALID(a_out_valid), .iOUT_BUSY(a_out_busy), .oOUT_DATA(a_out_data),
    .oOUT_TAG(a_out_tag), .oOUT_FAULT(a_out_fault)
  );

  // Depth 4 lets the 64-bit instance sustain one request per cycle.
  afe_ldst_align_pipe #(.P_DATA_W(64), .P_OFS_W(3), .P_TAG_W(5), .P_FIFO_DEPTH(4)) dut_b (
    .iCLOCK(clk), .iRESET_SYNC(rst), .iFLUSH(b_flush),
    .iREQ_VALID(b_req_valid), .oREQ_BUSY(b_req_busy), .iREQ_CODE(b_req_code),
    .iREQ_OFFSET(b_req_ofs), .iREQ_DATA(b_req_data), .iREQ_TAG(b_req_tag),
    .oOUT_VALID(b_out_valid), .iOUT_BUSY(b_out_busy), .oOUT_DATA(b_out_data),
    .oOUT_TAG(b_out_tag), .oOUT_FAULT(b_out_fault)
  );

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    logic        fault;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   checks = 0;
  int   errors = 0;
  int   b_pops = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && !a_flush && a_out_valid && !a_out_busy) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_out actual_tag=%0d required=none", a_out_tag);
      end else begin
        ea = qa.pop_front();
        check("a_data", {32'b0, a_out_data}, ea.data);
        check("a_tag", {59'b0, a_out_tag}, {59'b0, ea.tag});
        check("a_fault", {63'b0, a_out_fault}, {63'b0, ea.fault});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && !b_flush && b_out_valid && !b_out_busy) begin
      b_pops++;
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_out actual_tag=%0d required=none", b_out_tag);
      end else begin
        eb = qb.pop_front();
        check("b_data", b_out_data, eb.data);
        check("b_tag", {59'b0, b_out_tag}, {59'b0, eb.tag});
        check("b_fault", {63'b0, b_out_fault}, {63'b0, eb.fault});
      end
    end
  end

  task automatic issue_a(input logic [3:0] code, input logic [1:0] ofs, input logic [31:0] data,
                         input logic [4:0] tag, input logic [31:0] exp, input logic expf);
    bit   done = 1'b0;
    exp_t e;
    a_req_valid = 1'b1; a_req_code = code; a_req_ofs = ofs; a_req_data = data; a_req_tag = tag;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (!a_req_busy) begin
        e.data = {32'b0, exp}; e.tag = tag; e.fault = expf;
        qa.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    a_req_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL a_accept_timeout tag=%0d actual=busy required=accepted", tag);
    end
  endtask

  task automatic issue_b(input logic [3:0] code, input logic [2:0] ofs, input logic [63:0] data,
                         input logic [4:0] tag, input logic [63:0] exp, input logic expf,
                         output int waited);
    bit   done = 1'b0;
    exp_t e;
    waited = 0;
    b_req_valid = 1'b1; b_req_code = code; b_req_ofs = ofs; b_req_data = data; b_req_tag = tag;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (!b_req_busy) begin
        e.data = exp; e.tag = tag; e.fault = expf;
        qb.push_back(e);
        done = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clk); #1;
    end
    b_req_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL b_accept_timeout tag=%0d actual=busy required=accepted", tag);
    end
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((qa.size() != 0 || qb.size() != 0) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, 64'(qa.size() + qb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int w;
    int total_wait;
    rst = 1'b1;
    a_flush = 0; a_req_valid = 0; a_req_code = 0; a_req_ofs = 0; a_req_data = 0; a_req_tag = 0; a_out_busy = 0;
    b_flush = 0; b_req_valid = 0; b_req_code = 0; b_req_ofs = 0; b_req_data = 0; b_req_tag = 0; b_out_busy = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_a_valid", {63'b0, a_out_valid}, 64'd0);
    check("rst_a_data", {32'b0, a_out_data}, 64'd0);
    check("rst_a_tag", {59'b0, a_out_tag}, 64'd0);
    check("rst_a_fault", {63'b0, a_out_fault}, 64'd0);
    check("rst_a_busy", {63'b0, a_req_busy}, 64'd0);
    check("rst_b_valid", {63'b0, b_out_valid}, 64'd0);
    check("rst_b_data", b_out_data, 64'd0);
    @(posedge clk); #1;

    // Byte extract plus two-cycle latency
    issue_a(`AFE_LDST_SEXT8_32, 2'd2, 32'h1285_3456, 5'd1, 32'hFFFF_FF85, 1'b0);
    @(negedge clk);
    check("t1_valid_after_1", {63'b0, a_out_valid}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_valid_after_2", {63'b0, a_out_valid}, 64'd1);
    @(posedge clk); #1;
    issue_a(`AFE_LDST_ZEXT8_32,  2'd2, 32'h1285_3456, 5'd2, 32'h0000_0085, 1'b0);
    issue_a(`AFE_LDST_SEXT16_32, 2'd2, 32'h1285_3456, 5'd3, 32'h0000_1285, 1'b0);
    issue_a(`AFE_LDST_ZEXT16_32, 2'd0, 32'hFFFF_8001, 5'd4, 32'h0000_8001, 1'b0);
    issue_a(`AFE_LDST_SEXT16_32, 2'd0, 32'hFFFF_8001, 5'd5, 32'hFFFF_8001, 1'b0);
    issue_a(4'hF,                2'd1, 32'hCAFE_F00D, 5'd6, 32'hCAFE_F00D, 1'b0);
    issue_a(`AFE_LDST_SEXT32_64, 2'd1, 32'h89AB_CDEF, 5'd7, 32'h89AB_CDEF, 1'b0);
`ifdef AFE_LDST_MISALIGN_TRAP_EN
    issue_a(`AFE_LDST_SEXT16_32, 2'd3, 32'h8000_007F, 5'd8, 32'h0000_0000, 1'b1);
`else
    issue_a(`AFE_LDST_SEXT16_32, 2'd3, 32'h8000_007F, 5'd8, 32'h0000_7F80, 1'b0);
`endif
    issue_a(`AFE_LDST_ZEXT8_32,  2'd3, 32'hA100_0000, 5'd9, 32'h0000_00A1, 1'b0);
    issue_a(`AFE_LDST_NONE,      2'd3, 32'h1234_5678, 5'd10, 32'h1234_5678, 1'b0);
    wait_drain("t1_drain");

    // 64-bit datapath
    issue_b(`AFE_LDST_SEXT32_64, 3'd4, 64'h8000_0001_DEAD_BEEF, 5'd1, 64'hFFFF_FFFF_8000_0001, 1'b0, w);
    issue_b(`AFE_LDST_ZEXT32_64, 3'd4, 64'h8000_0001_DEAD_BEEF, 5'd2, 64'h0000_0000_8000_0001, 1'b0, w);
    issue_b(`AFE_LDST_NONE,      3'd3, 64'h0123_4567_89AB_CDEF, 5'd3, 64'h0123_4567_89AB_CDEF, 1'b0, w);
    issue_b(`AFE_LDST_ZEXT16_32, 3'd6, 64'h8000_1111_2222_3333, 5'd4, 64'h0000_0000_0000_8000, 1'b0, w);
    issue_b(`AFE_LDST_SEXT8_32,  3'd7, 64'h8000_1111_2222_3333, 5'd5, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, w);
    issue_b(`AFE_LDST_SEXT32_64, 3'd0, 64'hFFFF_0000_7FFF_FFFF, 5'd6, 64'h0000_0000_7FFF_FFFF, 1'b0, w);
    wait_drain("t2_drain");

    // Back-pressure on the depth-2 instance
    a_out_busy = 1'b1;
    issue_a(`AFE_LDST_ZEXT8_32, 2'd0, 32'h0000_000A, 5'd10, 32'h0000_000A, 1'b0);
    issue_a(`AFE_LDST_ZEXT8_32, 2'd0, 32'h0000_000B, 5'd11, 32'h0000_000B, 1'b0);
    a_req_valid = 1'b1; a_req_code = `AFE_LDST_ZEXT8_32; a_req_ofs = 2'd0;
    a_req_data = 32'h0000_000C; a_req_tag = 5'd12;
    @(negedge clk);
    check("t3_busy_full", {63'b0, a_req_busy}, 64'd1);
    check("t3_valid_stalled", {63'b0, a_out_valid}, 64'd1);
    check("t3_head_tag", {59'b0, a_out_tag}, 64'd10);
    @(posedge clk); #1;
    @(negedge clk);
    check("t3_head_data_stable", {32'b0, a_out_data}, 64'h0A);
    @(posedge clk); #1;
    a_out_busy = 1'b0;
    @(negedge clk);
    check("t3_busy_during_pop", {63'b0, a_req_busy}, 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t3_busy_after_pop", {63'b0, a_req_busy}, 64'd0);
    ea.data = 64'h0C; ea.tag = 5'd12; ea.fault = 1'b0;
    qa.push_back(ea);
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    wait_drain("t3_drain");

    // Flush with two pending and a request present
    a_out_busy = 1'b1;
    issue_a(`AFE_LDST_ZEXT8_32, 2'd0, 32'h0000_000D, 5'd13, 32'h0000_000D, 1'b0);
    issue_a(`AFE_LDST_ZEXT8_32, 2'd0, 32'h0000_000E, 5'd14, 32'h0000_000E, 1'b0);
    a_flush = 1'b1;
    a_req_valid = 1'b1; a_req_code = `AFE_LDST_ZEXT8_32; a_req_data = 32'h0000_000F; a_req_tag = 5'd15;
    @(negedge clk);
    check("t5_busy_in_flush", {63'b0, a_req_busy}, 64'd1);
    @(posedge clk); #1;
    a_flush = 1'b0;
    a_req_valid = 1'b0;
    qa.delete();
    @(negedge clk);
    check("t5_valid_after_flush", {63'b0, a_out_valid}, 64'd0);
    check("t5_busy_after_flush", {63'b0, a_req_busy}, 64'd0);
    @(posedge clk); #1;
    issue_a(`AFE_LDST_SEXT8_32, 2'd1, 32'h0000_FE00, 5'd16, 32'hFFFF_FFFE, 1'b0);
    issue_a(`AFE_LDST_ZEXT8_32, 2'd1, 32'h0000_FE00, 5'd17, 32'h0000_00FE, 1'b0);
    a_out_busy = 1'b0;
    wait_drain("t5_drain");

    // Reset mid-stream under stall, then a 16-deep back-to-back stream
    b_out_busy = 1'b1;
    issue_b(`AFE_LDST_SEXT8_32, 3'd0, 64'h0000_0000_0000_00FF, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, w);
    issue_b(`AFE_LDST_SEXT8_32, 3'd0, 64'h0000_0000_0000_00FF, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    qb.delete();
    @(negedge clk);
    check("t6_rst_valid", {63'b0, b_out_valid}, 64'd0);
    check("t6_rst_data", b_out_data, 64'd0);
    check("t6_rst_tag", {59'b0, b_out_tag}, 64'd0);
    check("t6_rst_fault", {63'b0, b_out_fault}, 64'd0);
    check("t6_rst_busy", {63'b0, b_req_busy}, 64'd0);
    check("t6_rst_a_data", {32'b0, a_out_data}, 64'd0);
    @(posedge clk); #1;
    b_out_busy = 1'b0;
    b_pops = 0;
    total_wait = 0;
    for (int i = 0; i < 16; i++) begin
      issue_b(`AFE_LDST_ZEXT8_32, 3'(i), 64'h8877_6655_4433_2211, 5'(i),
              64'((i % 8 + 1) * 8'h11), 1'b0, w);
      total_wait += w;
    end
    check("t6_no_bubbles", 64'(total_wait), 64'd0);
    wait_drain("t6_drain");
    check("t6_pop_count", 64'(b_pops), 64'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
